// File: rtl/bnn_sequencer_if.sv
// Image-load handshake and image-buffer write bus for the BNN sequencer.
// The master side streams image bytes in; the slave side is the sequencer.
interface bnn_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       load_we;
  logic [6:0] load_addr;
  logic [7:0] load_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  load_we,
    input  load_addr,
    input  load_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output load_we,
    output load_addr,
    output load_data
  );
endinterface

// File: rtl/bnn_sequencer.sv
// Top-level phase sequencer for a three-layer binary neural network:
// clears the layers, loads one image, steps through the layers with a per-layer timeout.
module bnn_sequencer #(
  parameter int unsigned LOAD_BYTES     = 98,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 l1_done,
  input  logic                 l2_done,
  input  logic                 l3_done,
  bnn_sequencer_if.slave       bus,
  output logic [2:0]           state,
  output logic                 layer_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LOAD    = 3'b001,
    S_LAYER_1 = 3'b010,
    S_LAYER_2 = 3'b011,
    S_LAYER_3 = 3'b100,
    S_DONE    = 3'b101,
    S_CLEAR   = 3'b110,
    S_ERR     = 3'b111
  } state_t;

  localparam logic [6:0]  LAST_BYTE   = 7'(LOAD_BYTES - 1);
  localparam logic [11:0] TIMEOUT_VAL = 12'(TIMEOUT_CYCLES);

  state_t      cur_state;
  state_t      nxt_state;
  logic [6:0]  byte_cnt;
  logic [6:0]  byte_cnt_nxt;
  logic [11:0] tmo_cnt;
  logic [11:0] tmo_cnt_nxt;
  logic        accept;
  logic        timed_out;
  logic        nxt_is_layer;

  assign accept    = (cur_state == S_LOAD) && bus.in_valid;
  assign timed_out = (tmo_cnt == TIMEOUT_VAL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      cur_state <= nxt_state;
      byte_cnt  <= byte_cnt_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    byte_cnt_nxt = byte_cnt;
    tmo_cnt_nxt  = '0;
    nxt_is_layer = 1'b0;

    unique case (cur_state)
      S_IDLE: begin
        if (start) nxt_state = S_CLEAR;
      end
      S_CLEAR: begin
        nxt_state = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_nxt = '0;
            nxt_state    = S_LAYER_1;
          end else begin
            byte_cnt_nxt = byte_cnt + 7'd1;
          end
        end
      end
      // Done flag is checked before the timeout so a simultaneous done wins.
      S_LAYER_1: begin
        if (l1_done)        nxt_state = S_LAYER_2;
        else if (timed_out) nxt_state = S_ERR;
      end
      S_LAYER_2: begin
        if (l2_done)        nxt_state = S_LAYER_3;
        else if (timed_out) nxt_state = S_ERR;
      end
      S_LAYER_3: begin
        if (l3_done)        nxt_state = S_DONE;
        else if (timed_out) nxt_state = S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start) nxt_state = S_CLEAR;
      end
      default: nxt_state = S_IDLE;
    endcase

    if (abort) begin
      nxt_state    = S_IDLE;
      byte_cnt_nxt = '0;
    end

    // Timeout counter restarts at zero whenever a layer state is (re)entered.
    nxt_is_layer = (nxt_state == S_LAYER_1) || (nxt_state == S_LAYER_2) ||
                   (nxt_state == S_LAYER_3);
    if (nxt_is_layer && (nxt_state == cur_state))
      tmo_cnt_nxt = tmo_cnt + 12'd1;
  end

  assign state         = cur_state;
  assign layer_rst_n   = rst_n && (cur_state != S_CLEAR);
  assign bus.in_ready  = rst_n && (cur_state == S_LOAD);
  assign bus.load_we   = rst_n && accept;
  assign bus.load_addr = byte_cnt;
  assign bus.load_data = bus.in_data;

  assign busy  = rst_n && ((cur_state == S_CLEAR) || (cur_state == S_LOAD) ||
                           (cur_state == S_LAYER_1) || (cur_state == S_LAYER_2) ||
                           (cur_state == S_LAYER_3));
  assign done  = rst_n && (cur_state == S_DONE);
  assign error = rst_n && (cur_state == S_ERR);

endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed-vector bench for bnn_sequencer with a shortened layer timeout.
module tb_bnn_sequencer;
  localparam int unsigned NB  = 98;
  localparam int unsigned TMO = 40;

  localparam logic [2:0] ST_IDLE = 3'b000, ST_LOAD = 3'b001, ST_L1 = 3'b010,
                         ST_L2 = 3'b011, ST_L3 = 3'b100, ST_DONE = 3'b101,
                         ST_CLEAR = 3'b110, ST_ERR = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, l1_done, l2_done, l3_done;
  logic [2:0] state;
  logic       layer_rst_n, busy, done, error;
  int         total = 0;
  int         bad = 0;

  bnn_sequencer_if bus();

  bnn_sequencer #(.LOAD_BYTES(NB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done),
    .bus(bus), .state(state), .layer_rst_n(layer_rst_n),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic load_all;
    for (int i = 0; i < int'(NB); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic abort_run;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%b exp=%b", state, ST_IDLE); end
    total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, error}); end
    total++; if ({bus.in_ready, bus.load_we} !== 2'b00) begin bad++; $display("FAIL reset_bus got=%b exp=00", {bus.in_ready, bus.load_we}); end
    total++; if (bus.load_addr !== 7'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.load_addr); end
    total++; if (layer_rst_n !== 1'b0) begin bad++; $display("FAIL reset_layer_rst got=%b exp=0", layer_rst_n); end
    rst_n = 1'b1;
    tick();
    total++; if (layer_rst_n !== 1'b1) begin bad++; $display("FAIL idle_layer_rst got=%b exp=1", layer_rst_n); end
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL idle_hold got=%b exp=%b", state, ST_IDLE); end
  endtask

  task automatic test_nominal;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (state !== ST_CLEAR) begin bad++; $display("FAIL nom_clear got=%b exp=%b", state, ST_CLEAR); end
    total++; if (layer_rst_n !== 1'b0) begin bad++; $display("FAIL nom_clear_rst got=%b exp=0", layer_rst_n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL nom_clear_busy got=%b exp=1", busy); end
    tick();
    total++; if (state !== ST_LOAD) begin bad++; $display("FAIL nom_load got=%b exp=%b", state, ST_LOAD); end
    total++; if (layer_rst_n !== 1'b1) begin bad++; $display("FAIL nom_load_rst got=%b exp=1", layer_rst_n); end
    for (int i = 0; i < int'(NB); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i) ^ 8'hA5;
      #1;
      total++;
      if (bus.load_we !== 1'b1 || bus.load_addr !== 7'(i) || bus.load_data !== (8'(i) ^ 8'hA5) ||
          bus.in_ready !== 1'b1 || state !== ST_LOAD) begin
        bad++;
        $display("FAIL nom_byte%0d got we=%b addr=%0d data=%h st=%b exp we=1 addr=%0d data=%h st=001",
                 i, bus.load_we, bus.load_addr, bus.load_data, state, i, 8'(i) ^ 8'hA5);
      end
      tick();
    end
    #1;
    total++; if (state !== ST_L1) begin bad++; $display("FAIL nom_l1 got=%b exp=%b", state, ST_L1); end
    total++; if ({bus.in_ready, bus.load_we} !== 2'b00) begin bad++; $display("FAIL nom_l1_bus got=%b exp=00", {bus.in_ready, bus.load_we}); end
    bus.in_valid = 1'b0;
    total++; if (bus.load_addr !== 7'd0) begin bad++; $display("FAIL nom_addr_clr got=%0d exp=0", bus.load_addr); end
    repeat (10) tick();
    total++; if (state !== ST_L1) begin bad++; $display("FAIL nom_l1_wait got=%b exp=%b", state, ST_L1); end
    l1_done = 1'b1; tick(); l1_done = 1'b0;
    total++; if (state !== ST_L2) begin bad++; $display("FAIL nom_l2 got=%b exp=%b", state, ST_L2); end
    repeat (10) tick();
    l2_done = 1'b1; tick(); l2_done = 1'b0;
    total++; if (state !== ST_L3) begin bad++; $display("FAIL nom_l3 got=%b exp=%b", state, ST_L3); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL nom_l3_busy got=%b exp=1", busy); end
    repeat (10) tick();
    l3_done = 1'b1; tick(); l3_done = 1'b0;
    total++; if (state !== ST_DONE) begin bad++; $display("FAIL nom_done got=%b exp=%b", state, ST_DONE); end
    total++; if ({busy, done, error} !== 3'b010) begin bad++; $display("FAIL nom_done_flags got=%b exp=010", {busy, done, error}); end
    repeat (5) tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL nom_done_hold got=%b exp=1", done); end
    abort_run();
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL nom_abort got=%b exp=%b", state, ST_IDLE); end
  endtask

  task automatic test_gapped;
    int pulses = 0;
    int last = -1;
    int k = 0;
    begin_run();
    while (state == ST_LOAD && k < 400) begin
      bus.in_valid = (k % 2) == 1;
      bus.in_data  = 8'(k);
      #1;
      if (bus.load_we === 1'b1) begin
        pulses++;
        last = int'(bus.load_addr);
      end
      tick();
      k++;
    end
    bus.in_valid = 1'b0;
    total++; if (pulses != 98) begin bad++; $display("FAIL gap_pulses got=%0d exp=98", pulses); end
    total++; if (last != 97) begin bad++; $display("FAIL gap_last_addr got=%0d exp=97", last); end
    total++; if (k != 196) begin bad++; $display("FAIL gap_cycles got=%0d exp=196", k); end
    total++; if (state !== ST_L1) begin bad++; $display("FAIL gap_l1 got=%b exp=%b", state, ST_L1); end
    abort_run();
  endtask

  task automatic test_timeout;
    int n = 0;
    begin_run();
    load_all();
    l1_done = 1'b1; tick(); l1_done = 1'b0;
    while (state == ST_L2 && n < 200) begin
      tick();
      n++;
    end
    total++; if (n != int'(TMO) + 1) begin bad++; $display("FAIL tmo_cycles got=%0d exp=%0d", n, TMO + 1); end
    total++; if (state !== ST_ERR) begin bad++; $display("FAIL tmo_err got=%b exp=%b", state, ST_ERR); end
    total++; if ({busy, done, error} !== 3'b001) begin bad++; $display("FAIL tmo_flags got=%b exp=001", {busy, done, error}); end
    l2_done = 1'b1; repeat (3) tick(); l2_done = 1'b0;
    total++; if (state !== ST_ERR) begin bad++; $display("FAIL tmo_hold got=%b exp=%b", state, ST_ERR); end
    start = 1'b1; tick(); start = 1'b0;
    total++; if (state !== ST_CLEAR || layer_rst_n !== 1'b0) begin bad++; $display("FAIL tmo_restart got st=%b lr=%b exp st=110 lr=0", state, layer_rst_n); end
    tick();
    total++; if (state !== ST_LOAD || layer_rst_n !== 1'b1) begin bad++; $display("FAIL tmo_clear_once got st=%b lr=%b exp st=001 lr=1", state, layer_rst_n); end
    abort_run();
  endtask

  task automatic test_race;
    begin_run();
    load_all();
    repeat (TMO) tick();
    total++; if (state !== ST_L1) begin bad++; $display("FAIL race_pre got=%b exp=%b", state, ST_L1); end
    l1_done = 1'b1; tick(); l1_done = 1'b0;
    total++; if (state !== ST_L2) begin bad++; $display("FAIL race_done_wins got=%b exp=%b", state, ST_L2); end
    abort_run();
  endtask

  task automatic test_abort;
    begin_run();
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      start = (i == 20);
      tick();
      if (i == 20) begin
        total++; if (state !== ST_LOAD || bus.load_addr !== 7'd21) begin bad++; $display("FAIL abort_start_ignored got st=%b addr=%0d exp st=001 addr=21", state, bus.load_addr); end
      end
    end
    start = 1'b0;
    total++; if (bus.load_addr !== 7'd40) begin bad++; $display("FAIL abort_addr40 got=%0d exp=40", bus.load_addr); end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL abort_idle got=%b exp=%b", state, ST_IDLE); end
    begin_run();
    bus.in_valid = 1'b1;
    #1;
    total++; if (bus.load_we !== 1'b1 || bus.load_addr !== 7'd0) begin bad++; $display("FAIL abort_restart got we=%b addr=%0d exp we=1 addr=0", bus.load_we, bus.load_addr); end
    bus.in_valid = 1'b0;
    abort_run();
  endtask

  task automatic test_stale_done;
    l2_done = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    total++; if (state !== ST_CLEAR || layer_rst_n !== 1'b0) begin bad++; $display("FAIL stale_clear got st=%b lr=%b exp st=110 lr=0", state, layer_rst_n); end
    tick();
    load_all();
    l3_done = 1'b1;
    repeat (5) tick();
    l3_done = 1'b0;
    total++; if (state !== ST_L1) begin bad++; $display("FAIL stale_l1_hold got=%b exp=%b", state, ST_L1); end
    l1_done = 1'b1; tick(); l1_done = 1'b0;
    total++; if (state !== ST_L2) begin bad++; $display("FAIL stale_l2_entry got=%b exp=%b", state, ST_L2); end
    tick();
    l2_done = 1'b0;
    total++; if (state !== ST_L3) begin bad++; $display("FAIL stale_l3 got=%b exp=%b", state, ST_L3); end
    l3_done = 1'b1; tick(); l3_done = 1'b0;
    total++; if (state !== ST_DONE) begin bad++; $display("FAIL stale_done got=%b exp=%b", state, ST_DONE); end
    start = 1'b1; tick(); start = 1'b0;
    total++; if (state !== ST_CLEAR) begin bad++; $display("FAIL done_restart got=%b exp=%b", state, ST_CLEAR); end
    abort_run();
  endtask

  task automatic test_mid_reset;
    begin_run();
    bus.in_valid = 1'b1; repeat (5) tick(); bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    total++; if (state !== ST_IDLE || bus.load_addr !== 7'd0) begin bad++; $display("FAIL midrst got st=%b addr=%0d exp st=000 addr=0", state, bus.load_addr); end
    total++; if (layer_rst_n !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_out got lr=%b busy=%b exp lr=0 busy=0", layer_rst_n, busy); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    test_reset();
    test_nominal();
    test_gapped();
    test_timeout();
    test_race();
    test_abort();
    test_stale_done();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bnn_sequencer.md
BNN_SEQUENCER -- requirements
Module: bnn_sequencer

Interface
REQ-001 Parameter LOAD_BYTES, default 98: number of 8-bit input-image bytes per inference (784 binary pixels).
REQ-002 Parameter TIMEOUT_CYCLES, default 4095: maximum cycles allowed in any layer state before a fault is declared.
REQ-003 clk  input  1  clock; all logic updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request a new inference; sampled in IDLE, DONE and ERR only.
REQ-006 abort  input  1  return to IDLE from any state.
REQ-007 in_valid  input  1  input byte valid.
REQ-008 in_data  input  8  input image byte.
REQ-009 in_ready  output  1  sequencer accepts a byte this cycle.
REQ-010 l1_done, l2_done, l3_done  input  1 each  level done flags from layer one, layer two and layer three.
REQ-011 state  output  3  phase code broadcast to all layers.
REQ-012 layer_rst_n  output  1  active-low clear to the layer datapaths.
REQ-013 load_we  output  1  image buffer write strobe.
REQ-014 load_addr  output  7  image buffer byte address.
REQ-015 load_data  output  8  image buffer write data.
REQ-016 busy  output  1  an inference is in progress.
REQ-017 done  output  1  inference complete.
REQ-018 error  output  1  layer timeout fault.

Function
REQ-019 State encodings SHALL be: IDLE=000, LOAD=001, LAYER_1=010, LAYER_2=011, LAYER_3=100, DONE=101, CLEAR=110, ERR=111; the state output SHALL be the registered state.
REQ-020 IDLE SHALL move to CLEAR when start=1.
REQ-021 CLEAR SHALL last exactly one cycle, then move to LOAD.
REQ-022 layer_rst_n SHALL be 0 while rst_n=0 or state=CLEAR, and 1 otherwise (combinational).
REQ-023 In LOAD: in_ready=1; an accepted byte (in_valid&in_ready) SHALL assert load_we the same cycle, with load_addr=byte counter and load_data=in_data; the counter SHALL then increment.
REQ-024 On accepting byte LOAD_BYTES-1, the sequencer SHALL clear the counter and move to LAYER_1 on the next edge; in_ready=0 and load_we=0 outside LOAD.
REQ-025 LAYER_1 SHALL move to LAYER_2 on l1_done=1; LAYER_2 SHALL move to LAYER_3 on l2_done=1; LAYER_3 SHALL move to DONE on l3_done=1.
REQ-026 A 12-bit timeout counter SHALL clear on entry to each layer state and increment every cycle spent in that state.
REQ-027 If the counter equals TIMEOUT_CYCLES and the current layer's done flag is 0, the sequencer SHALL move to ERR; a done flag in that same cycle SHALL win.
REQ-028 DONE and ERR SHALL hold until start (move to CLEAR) or abort (move to IDLE).
REQ-029 busy SHALL be 1 in CLEAR, LOAD and LAYER_1..3; done=1 only in DONE; error=1 only in ERR.
REQ-030 abort SHALL override start, done flags and timeout in every state: next state IDLE, byte counter and timeout counter cleared.
REQ-031 start outside IDLE, DONE and ERR SHALL be ignored.
REQ-032 Done flags seen outside their own layer state SHALL be ignored.
REQ-033 An input stall (in_valid=0) in LOAD SHALL not time out.

Reset
REQ-034 On rst_n=0: state=IDLE; byte and timeout counters=0; busy=done=error=in_ready=load_we=0; load_addr=0; layer_rst_n=0.
REQ-035 Reset SHALL take effect mid-inference from any state on the next edge.

Verification
REQ-036 Nominal run: start pulse, then 98 bytes back-to-back, then l1_done, l2_done, l3_done, each 10 cycles after its state is entered -> state sequence 110,001,010,011,100,101; load_addr runs 0..97; done=1 from the first DONE cycle onward.
REQ-037 Gapped load: in_valid toggles every cycle -> exactly 98 load_we pulses; LAYER_1 entered only after byte 97.
REQ-038 Timeout: l2_done never asserted -> ERR after TIMEOUT_CYCLES cycles in LAYER_2, error=1, busy=0; a following start -> CLEAR with layer_rst_n=0 for one cycle.
REQ-039 Race: l1_done rises in the same cycle the counter reaches TIMEOUT_CYCLES -> next state LAYER_2, not ERR.
REQ-040 Abort: abort and start both asserted during LOAD at byte 40 -> next state IDLE; a new start restarts at load_addr=0.
REQ-041 Stale done: l2_done held high from a prior run -> the CLEAR pulse occurs; l2_done asserted during LAYER_1 has no effect; LAYER_2 is entered only via l1_done.
